// File: rtl/slave_responder.sv
// Memory-backed crossbar slave: captures a request, waits a fixed number of cycles,
// then completes with a one-cycle ack; counts completed reads and writes.
module slave_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic        i_cmd,
    input  logic [31:0] i_wdata,
    output logic        o_ack,
    output logic [31:0] o_rdata,
    output logic [15:0] o_rd_cnt,
    output logic [15:0] o_wr_cnt
);
    // state  | meaning
    // S_IDLE | waiting for req; captures addr/cmd/wdata when req=1
    // S_WAIT | counting down wait states
    // S_ACK  | ack high for this cycle; memory/rdata/counters updated on entry
    // S_TURN | one dead cycle, req ignored
    localparam int         AW      = $clog2(DEPTH);
    localparam logic [7:0] WAIT_LD = 8'(WAIT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_TURN} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [7:0]    r_wait_cnt;
    logic [AW-1:0] r_idx;
    logic          r_cmd;
    logic [31:0]   r_wdata;
    logic          r_ack;
    logic [31:0]   r_rdata;
    logic [15:0]   r_rd_cnt;
    logic [15:0]   r_wr_cnt;
    logic [31:0]   r_mem [DEPTH] = '{default: '0};

    logic          w_capture;
    logic          w_fire;
    logic          w_fire_wr;
    logic          w_fire_rd;
    logic [AW-1:0] w_idx;
    logic          w_cmd;
    logic [31:0]   w_wdata;
    logic          w_unused_addr;

    assign w_unused_addr = ^{i_addr[31:AW+2], i_addr[1:0]};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_req) w_state_nxt = (WAIT_CYCLES == 0) ? S_ACK : S_WAIT;
            S_WAIT:  if (r_wait_cnt <= 8'd1) w_state_nxt = S_ACK;
            S_ACK:   w_state_nxt = S_TURN;
            S_TURN:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // With zero wait states the completing edge is also the capture edge,
    // so the transaction fields bypass the capture registers.
    always_comb begin
        w_capture = (r_state == S_IDLE) && i_req;
        w_fire    = resetn && (w_state_nxt == S_ACK);
        w_idx     = w_capture ? i_addr[AW+1:2] : r_idx;
        w_cmd     = w_capture ? i_cmd : r_cmd;
        w_wdata   = w_capture ? i_wdata : r_wdata;
        w_fire_wr = w_fire && w_cmd;
        w_fire_rd = w_fire && !w_cmd;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wait_cnt <= 8'd0;
            r_idx      <= '0;
            r_cmd      <= 1'b0;
            r_wdata    <= 32'h0;
            r_ack      <= 1'b0;
            r_rdata    <= 32'h0;
            r_rd_cnt   <= 16'h0;
            r_wr_cnt   <= 16'h0;
        end else begin
            r_ack <= w_fire;
            if (w_capture) begin
                r_idx      <= i_addr[AW+1:2];
                r_cmd      <= i_cmd;
                r_wdata    <= i_wdata;
                r_wait_cnt <= WAIT_LD;
            end else if (r_state == S_WAIT) begin
                r_wait_cnt <= r_wait_cnt - 8'd1;
            end
            if (w_fire_rd) begin
                r_rdata <= r_mem[w_idx];
                if (r_rd_cnt != 16'hFFFF) r_rd_cnt <= r_rd_cnt + 16'd1;
            end
            if (w_fire_wr && (r_wr_cnt != 16'hFFFF)) r_wr_cnt <= r_wr_cnt + 16'd1;
        end
    end

    // Memory is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (w_fire_wr) r_mem[w_idx] <= w_wdata;
    end

    assign o_ack    = r_ack;
    assign o_rdata  = r_rdata;
    assign o_rd_cnt = r_rd_cnt;
    assign o_wr_cnt = r_wr_cnt;

endmodule

// File: tb/tb_slave_responder.sv
// Bench for slave_responder: table vectors, hand-written corner sequences and
// random transactions checked against an address-indexed memory model.
module tb_slave_responder;

    logic        clk;
    logic        resetn;
    logic        req0, cmd0, ack0;
    logic [31:0] addr0, wdata0, rdata0;
    logic [15:0] rdc0, wrc0;
    logic        req1, cmd1, ack1;
    logic [31:0] addr1, wdata1, rdata1;
    logic [15:0] rdc1, wrc1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mdl_mem [int];
    int          mdl_rd, mdl_wr;
    logic [31:0] mdl_rdata;

    typedef struct {
        logic        cmd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[9];

    slave_responder #(.DEPTH(256), .WAIT_CYCLES(2)) u0 (
        .clk(clk), .resetn(resetn), .i_req(req0), .i_addr(addr0), .i_cmd(cmd0),
        .i_wdata(wdata0), .o_ack(ack0), .o_rdata(rdata0), .o_rd_cnt(rdc0), .o_wr_cnt(wrc0)
    );

    slave_responder #(.DEPTH(16), .WAIT_CYCLES(0)) u1 (
        .clk(clk), .resetn(resetn), .i_req(req1), .i_addr(addr1), .i_cmd(cmd1),
        .i_wdata(wdata1), .o_ack(ack1), .o_rdata(rdata1), .o_rd_cnt(rdc1), .o_wr_cnt(wrc1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a / 32'd4) % 32'd256);
    endfunction

    function automatic int sat(input int v);
        return (v < 65535) ? v + 1 : 65535;
    endfunction

    // mode bit0: scramble inputs after capture; bit1: drop req during wait;
    // bit2: release reset on the same negedge that raises req
    task automatic txn(input logic cmd, input logic [31:0] addr, input logic [31:0] wd,
                       input int mode, input string tag);
        int          lat;
        logic [31:0] exp_rd;
        @(negedge clk);
        if (mode[2]) resetn = 1'b1;
        req0 = 1'b1; cmd0 = cmd; addr0 = addr; wdata0 = wd;
        lat = -1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (ack0) begin
                lat = k;
                break;
            end
            if (k == 0 && mode[0]) begin
                addr0 = $urandom; cmd0 = ~cmd; wdata0 = $urandom;
            end
            if (k == 0 && mode[1]) req0 = 1'b0;
        end
        req0 = 1'b0;
        if (cmd) begin
            mdl_mem[widx(addr)] = wd;
            mdl_wr = sat(mdl_wr);
            exp_rd = mdl_rdata;
        end else begin
            exp_rd = mdl_mem.exists(widx(addr)) ? mdl_mem[widx(addr)] : 32'h0;
            mdl_rdata = exp_rd;
            mdl_rd = sat(mdl_rd);
        end
        check({tag, ":latency"}, 64'(lat), 64'd2);
        check({tag, ":rdata"}, 64'(rdata0), 64'(exp_rd));
        check({tag, ":rd_cnt"}, 64'(rdc0), 64'(mdl_rd));
        check({tag, ":wr_cnt"}, 64'(wrc0), 64'(mdl_wr));
        @(negedge clk);
        check({tag, ":ack_one_cycle"}, 64'(ack0), 64'd0);
    endtask

    initial begin
        int          acks[$];
        int          lat;
        logic        seen;
        logic [31:0] a;

        vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0};
        vecs[1] = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 32'h8000_0010, 32'h1234_5678, 32'h0};
        vecs[3] = '{1'b0, 32'h0000_0010, 32'h0,         32'h1234_5678};
        vecs[4] = '{1'b1, 32'h0000_0400, 32'hA5A5_A5A5, 32'h0};
        vecs[5] = '{1'b0, 32'h0000_0000, 32'h0,         32'hA5A5_A5A5};
        vecs[6] = '{1'b0, 32'h0000_0013, 32'h0,         32'h1234_5678};
        vecs[7] = '{1'b1, 32'h0000_03FC, 32'hFFFF_FFFF, 32'h0};
        vecs[8] = '{1'b0, 32'h7FFF_FFFC, 32'h0,         32'hFFFF_FFFF};

        resetn = 1'b0;
        req0 = 0; cmd0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; cmd1 = 0; addr1 = 0; wdata1 = 0;
        mdl_rd = 0; mdl_wr = 0; mdl_rdata = 32'h0;
        repeat (3) @(negedge clk);
        check("reset:ack", 64'(ack0), 64'd0);
        check("reset:rdata", 64'(rdata0), 64'd0);
        check("reset:rd_cnt", 64'(rdc0), 64'd0);
        check("reset:wr_cnt", 64'(wrc0), 64'd0);
        check("reset:u1_ack", 64'(ack1), 64'd0);
        check("reset:u1_rdata", 64'(rdata1), 64'd0);
        resetn = 1'b1;

        for (int i = 0; i < 9; i++) begin
            txn(vecs[i].cmd, vecs[i].addr, vecs[i].wdata, 0, $sformatf("vec%0d", i));
            if (!vecs[i].cmd) check($sformatf("vec%0d:table_rdata", i), 64'(rdata0), 64'(vecs[i].exp));
        end

        // Inputs change after capture; then req dropped during wait.
        txn(1'b1, 32'h20, 32'h1111_1111, 1, "scramble_wr");
        txn(1'b0, 32'h20, 32'h0, 0, "scramble_rd");
        check("scramble:rdata", 64'(rdata0), 64'h1111_1111);
        txn(1'b1, 32'h24, 32'h7777_0000, 2, "drop_wr");
        txn(1'b0, 32'h24, 32'h0, 2, "drop_rd");

        // Reset during the wait phase of a write abandons it.
        @(negedge clk);
        req0 = 1'b1; cmd0 = 1'b1; addr0 = 32'h30; wdata0 = 32'hCAFE_F00D;
        @(negedge clk);
        req0 = 1'b0; resetn = 1'b0;
        #1;
        seen = ack0;
        check("rst_mid:wr_cnt", 64'(wrc0), 64'd0);
        check("rst_mid:rd_cnt", 64'(rdc0), 64'd0);
        check("rst_mid:rdata", 64'(rdata0), 64'd0);
        repeat (3) begin
            @(negedge clk);
            seen = seen | ack0;
        end
        check("rst_mid:no_ack", 64'(seen), 64'd0);
        mdl_rd = 0; mdl_wr = 0; mdl_rdata = 32'h0;
        txn(1'b0, 32'h30, 32'h0, 4, "rst_rd");
        check("rst_mid:mem_kept", 64'(rdata0), 64'h0);

        // Held read request: three services spaced WAIT_CYCLES+3 apart.
        @(negedge clk);
        req0 = 1'b1; cmd0 = 1'b0; addr0 = 32'h10;
        acks.delete();
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (ack0) begin
                acks.push_back(k);
                check("held:rdata", 64'(rdata0), 64'h1234_5678);
            end
            if (k == 14) req0 = 1'b0;
        end
        mdl_rd += 3;
        mdl_rdata = 32'h1234_5678;
        check("held:n_acks", 64'(acks.size()), 64'd3);
        check("held:first", 64'((acks.size() > 0) ? acks[0] : -1), 64'd2);
        check("held:gap1", 64'((acks.size() > 1) ? acks[1] - acks[0] : -1), 64'd5);
        check("held:gap2", 64'((acks.size() > 2) ? acks[2] - acks[1] : -1), 64'd5);
        check("held:rd_cnt", 64'(rdc0), 64'(mdl_rd));

        // Zero wait states, DEPTH=16: held write then an aliased read.
        @(negedge clk);
        req1 = 1'b1; cmd1 = 1'b1; addr1 = 32'h44; wdata1 = 32'h5A5A_0001;
        acks.delete();
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (ack1) acks.push_back(k);
            if (k == 8) req1 = 1'b0;
        end
        check("w0_held:n_acks", 64'(acks.size()), 64'd3);
        check("w0_held:first", 64'((acks.size() > 0) ? acks[0] : -1), 64'd0);
        check("w0_held:gap1", 64'((acks.size() > 1) ? acks[1] - acks[0] : -1), 64'd3);
        check("w0_held:gap2", 64'((acks.size() > 2) ? acks[2] - acks[1] : -1), 64'd3);
        check("w0_held:wr_cnt", 64'(wrc1), 64'd3);
        @(negedge clk);
        req1 = 1'b1; cmd1 = 1'b0; addr1 = 32'h8000_0004;
        lat = -1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (ack1) begin
                lat = k;
                break;
            end
        end
        req1 = 1'b0;
        check("w0_rd:latency", 64'(lat), 64'd0);
        check("w0_rd:rdata", 64'(rdata1), 64'h5A5A_0001);
        check("w0_rd:rd_cnt", 64'(rdc1), 64'd1);

        // Write counter saturation.
        @(negedge clk);
        force u0.r_wr_cnt = 16'hFFFE;
        #1;
        release u0.r_wr_cnt;
        mdl_wr = 65534;
        check("sat:preload", 64'(wrc0), 64'hFFFE);
        for (int i = 0; i < 3; i++) txn(1'b1, 32'h40 + 32'(i * 4), 32'hBEE0_0000 + 32'(i), 0, "sat");
        check("sat:final", 64'(wrc0), 64'hFFFF);

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            a[9:2] = 8'($urandom_range(0, 255)) & 8'h87;
            txn(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3), $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
